// File: rtl/led_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : led_pkg
// Brief    : Shared mode encodings, ramp direction type and dim-level helper.
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam logic [1:0] MODE_BREATHE = 2'd0;
  localparam logic [1:0] MODE_SCAN    = 2'd1;
  localparam logic [1:0] MODE_BINARY  = 2'd2;
  localparam logic [1:0] MODE_ON      = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Neighbour glow of the scanner: one eighth of full PWM scale.
  function automatic int dim_level(input int pwm_bits);
    return (1 << pwm_bits) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_driver_tick_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tick_div
// Brief    : Enable-gated modulo-N counter; one-cycle pulse every N enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tick_div #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_pulse
);

  localparam int                c_cnt_w = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Pulse is combinational so a downstream divider enabled by it sees the same cycle.
  assign o_pulse = i_en && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_pulse ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : led_pattern_driver
// Brief    : Board LED display stage: breathing, scanner, binary count, all-on.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STEP_HZ    = 500,
  parameter int PWM_BITS   = 8,
  parameter int SCAN_STEPS = 25,
  parameter int NLEDS      = 10
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [1:0]       SW,
  input  logic             EN,
  output logic [NLEDS-1:0] LEDR
);

  localparam int                  c_div      = CLK_HZ / STEP_HZ;
  localparam int                  c_pos_w    = $clog2(NLEDS);
  localparam logic [PWM_BITS-1:0] c_max      = '1;
  localparam logic [PWM_BITS-1:0] c_dim      = PWM_BITS'(dim_level(PWM_BITS));
  localparam logic [c_pos_w-1:0]  c_pos_last = c_pos_w'(NLEDS - 1);

  logic [1:0]          r_sw_meta, r_sw_s;
  logic                r_en_meta, r_en_s;
  logic [PWM_BITS-1:0] r_pwm_cnt, r_lvl;
  dir_e                r_dir, r_sdir;
  logic [c_pos_w-1:0]  r_pos;
  logic [NLEDS-1:0]    r_bin, r_led;
  logic [NLEDS-1:0]    w_scan_led, w_led_next;
  logic                w_step, w_scan, w_pwm_on, w_dim;

  tick_div #(.N(c_div)) u_prescale (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .i_en    (r_en_s),
    .o_pulse (w_step)
  );

  tick_div #(.N(SCAN_STEPS)) u_scan_div (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .i_en    (w_step),
    .o_pulse (w_scan)
  );

  assign w_pwm_on = (r_pwm_cnt < r_lvl);
  assign w_dim    = (r_pwm_cnt < c_dim);

  // Edge LEDs have only one neighbour; guards keep i+1 from aliasing when NLEDS is a power of two.
  for (genvar i = 0; i < NLEDS; i++) begin : g_scan
    logic w_left, w_right;
    if (i > 0) begin : g_has_left
      assign w_left = (r_pos == c_pos_w'(i - 1));
    end else begin : g_no_left
      assign w_left = 1'b0;
    end
    if (i < NLEDS - 1) begin : g_has_right
      assign w_right = (r_pos == c_pos_w'(i + 1));
    end else begin : g_no_right
      assign w_right = 1'b0;
    end
    assign w_scan_led[i] = (r_pos == c_pos_w'(i)) | ((w_left | w_right) & w_dim);
  end

  always_comb begin
    w_led_next = '0;
    case (r_sw_s)
      MODE_BREATHE: w_led_next = {NLEDS{w_pwm_on}};
      MODE_SCAN:    w_led_next = w_scan_led;
      MODE_BINARY:  w_led_next = r_bin;
      MODE_ON:      w_led_next = '1;
      default:      w_led_next = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
      r_en_meta <= 1'b0;
      r_en_s    <= 1'b0;
      r_pwm_cnt <= '0;
      r_lvl     <= '0;
      r_dir     <= DIR_UP;
      r_pos     <= '0;
      r_sdir    <= DIR_UP;
      r_bin     <= '0;
      r_led     <= '0;
    end else begin
      r_sw_meta <= SW;
      r_sw_s    <= r_sw_meta;
      r_en_meta <= EN;
      r_en_s    <= r_en_meta;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_led     <= w_led_next;

      if (w_step) begin
        if (r_dir == DIR_UP) begin
          if (r_lvl == c_max) begin
            r_dir <= DIR_DOWN;
            r_lvl <= c_max - PWM_BITS'(1);
          end else begin
            r_lvl <= r_lvl + PWM_BITS'(1);
          end
        end else if (r_lvl == '0) begin
          r_dir <= DIR_UP;
          r_lvl <= PWM_BITS'(1);
        end else begin
          r_lvl <= r_lvl - PWM_BITS'(1);
        end
      end

      if (w_scan) begin
        r_bin <= r_bin + NLEDS'(1);
        if (r_sdir == DIR_UP) begin
          if (r_pos == c_pos_last) begin
            r_sdir <= DIR_DOWN;
            r_pos  <= c_pos_last - c_pos_w'(1);
          end else begin
            r_pos <= r_pos + c_pos_w'(1);
          end
        end else if (r_pos == '0) begin
          r_sdir <= DIR_UP;
          r_pos  <= c_pos_w'(1);
        end else begin
          r_pos <= r_pos - c_pos_w'(1);
        end
      end
    end
  end

  assign LEDR = r_led;

endmodule
`default_nettype wire

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
- Downstream display stage for the board LEDs.
- Takes the 50 MHz board clock and runs its own step prescaler and PWM counter.
- Drives LEDR with one of four patterns: breathing, bouncing scanner, binary count, all-on.
- Replaces a raw free-running counter driving LEDR directly. Pattern selected by SW, motion paused by EN.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- STEP_HZ, 500, brightness step rate. DIV = CLK_HZ/STEP_HZ; must be an integer ≥ 2.
- PWM_BITS, 8, width of PWM counter and brightness level.
- SCAN_STEPS, 25, brightness steps per scanner/binary advance.
- NLEDS, 10, number of LED outputs; must be ≥ 3.

Ports:
- CLOCK_50  in   1         system clock.
- RESET_N   in   1         asynchronous active-low reset.
- SW        in   2         pattern select (asynchronous, from switches).
- EN        in   1         1 = patterns advance, 0 = freeze motion (asynchronous).
- LEDR      out  NLEDS     registered LED drive.

Behaviour:
Clock/reset (already decided): one clock, CLOCK_50. Reset is RESET_N, asynchronous, active-low. All flops clear immediately on RESET_N=0.

Reset values:
- LEDR=0; all counters=0.
- lvl=0, dir=up, pos=0, sdir=up, bin=0.
- Synchronizer flops = 0.

Synchronizers:
- SW and EN each pass through 2-flop synchronizers. Logic uses only the synchronized values sw_s and en_s.

Prescaler:
- div counts 0..DIV-1.
- step is a 1-cycle pulse when div==DIV-1 and en_s=1; div then wraps to 0.
- en_s=0: div holds and no step is produced.

PWM:
- pwm_cnt (PWM_BITS) increments every cycle, wraps MAX→0, where MAX = 2^PWM_BITS−1.
- Never gated by EN.
- pwm_on = (pwm_cnt < lvl).
- lvl=0 gives always off; lvl=MAX gives on for MAX of 2^PWM_BITS cycles.

Brightness ramp (on step only):
- dir=up: if lvl==MAX, set dir=down and lvl=MAX−1; else lvl+1.
- dir=down: if lvl==0, set dir=up and lvl=1; else lvl−1.
- Sequence: 0,1,…,MAX,MAX−1,…,0,1,…
- Period is 2·MAX steps. Endpoints are each visited once per period.

Scan tick:
- scnt counts steps 0..SCAN_STEPS−1.
- scan is a 1-cycle pulse coincident with the step that wraps scnt.

Scanner (on scan):
- sdir=up: if pos==NLEDS−1, set sdir=down and pos=NLEDS−2; else pos+1.
- Mirror at 0.
- Sequence: 0..NLEDS−1, NLEDS−2..0, 1…

Binary (on scan):
- bin (NLEDS bits) increments; wraps all-ones→0.

Pattern registers:
- lvl, pos and bin advance in every mode. A mode switch changes only the output mux.

Output (registered, one cycle after mux inputs):
- sw_s=0, BREATHE: all LEDs = pwm_on.
- sw_s=1, SCAN: LEDR[pos]=1; LEDR[pos±1] = (pwm_cnt < DIM_LEVEL) where the index exists; all other LEDs 0.
- sw_s=2, BINARY: LEDR = bin.
- sw_s=3, ON: all ones.

Latency:
- SW or EN change → effect visible on LEDR after 3 clock edges (2 synchronizer + 1 output).

Simultaneous events:
- step and scan coincide by construction. lvl, pos and bin all update on that same edge.

Reset mid-operation:
- LEDR drops to 0 asynchronously.
- After release, the first step occurs DIV cycles after the synchronized en_s reaches 1.

Decomposition:
- Package led_pkg holds:
  - MODE_BREATHE=0, MODE_SCAN=1, MODE_BINARY=2, MODE_ON=3 (2-bit).
  - DIM_LEVEL = 2^PWM_BITS/8.
- Sub-module tick_div(N):
  - Ports: clock, reset, enable in; pulse out.
  - Pulses every N enabled cycles.
  - Instantiated twice: prescaler (N=DIV, enable=en_s) and scan divider (N=SCAN_STEPS, enable=step).

Test Plan:
Bench uses CLK_HZ=1000, STEP_HZ=100 (DIV=10), PWM_BITS=4, SCAN_STEPS=2, NLEDS=10, EN=1 unless stated.
1. Reset: assert RESET_N=0 mid-run with LEDR≠0 → LEDR=0 before the next edge. Release with EN=1 → first step 12 cycles later (2 sync + 10).
2. BREATHE ramp: lvl follows 0..15,14..0,1 at one step per 10 cycles. At lvl=4, LEDR=0x3FF for exactly 4 of every 16 cycles.
3. PWM bounds: lvl=0 → LEDR=0 for a full 16-cycle window. lvl=15 → 0x3FF for 15 of 16 cycles.
4. SCAN: pos advances every 20 cycles through 0..9,8..0. At pos=0, LEDR[0]=1 constantly, LEDR[1] high only when pwm_cnt<2, LEDR[9:2]=0.
5. BINARY: bin increments every 20 cycles. Force bin=0x3FF → next scan gives 0x000.
6. EN=0 for 100 cycles: lvl, pos and bin frozen while pwm_cnt keeps running. Change SW 0→3 → LEDR=0x3FF exactly 3 edges later.
